// File: rtl/mouse_packet_decoder_if.sv
// Byte-stream input and per-frame displacement/button outputs of the
// PS/2 mouse packet decoder.
interface mouse_packet_decoder_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       frame_tick;
  logic [7:0] X_displ;
  logic [7:0] Y_displ;
  logic       Left;
  logic       Right;
  logic       Middle;
  logic       pkt_err;

  modport master (
    output byte_in, byte_valid, frame_tick,
    input  X_displ, Y_displ, Left, Right, Middle, pkt_err
  );

  modport slave (
    input  byte_in, byte_valid, frame_tick,
    output X_displ, Y_displ, Left, Right, Middle, pkt_err
  );
endinterface

// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 mouse packets and reports one saturated signed
// X/Y displacement pair per frame, Y inverted so positive is down.
module mouse_packet_decoder #(
  parameter int SYNC_TIMEOUT = 100000,
  parameter int ACC_W        = 12
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  mouse_packet_decoder_if.slave bus
);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;

  localparam int TMO_W     = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam int EXT_W     = ACC_W + 2;
  localparam int ACC_MAX_I = (1 << (ACC_W - 1)) - 1;

  localparam logic signed [EXT_W-1:0] SAT_HI = EXT_W'(ACC_MAX_I);
  localparam logic signed [EXT_W-1:0] SAT_LO = -SAT_HI;
  localparam logic signed [ACC_W-1:0] OUT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] OUT_LO = -OUT_HI;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI[ACC_W-1:0];
    end else if (v < SAT_LO) begin
      r = SAT_LO[ACC_W-1:0];
    end else begin
      r = v[ACC_W-1:0];
    end
    return r;
  endfunction

  // -128 is never produced so downstream negation stays symmetric.
  function automatic logic [7:0] clamp_out(input logic signed [ACC_W-1:0] a);
    logic [7:0] r;
    if (a > OUT_HI) begin
      r = 8'h7F;
    end else if (a < OUT_LO) begin
      r = 8'h81;
    end else begin
      r = a[7:0];
    end
    return r;
  endfunction

  function automatic logic signed [8:0] motion(input logic ovf, input logic sgn,
                                               input logic [7:0] mag);
    logic signed [8:0] r;
    if (ovf) begin
      r = sgn ? 9'h100 : 9'h0FF;
    end else begin
      r = {sgn, mag};
    end
    return r;
  endfunction

  logic [1:0]              state_r, state_s;
  logic [7:0]              b0_r, b1_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic signed [ACC_W-1:0] acc_x_r, acc_y_r, acc_x_s, acc_y_s;
  logic [7:0]              x_displ_r, y_displ_r;
  logic                    left_r, right_r, middle_r, pkt_err_r;
  logic                    in_pkt_s, expire_s, sync_err_s, complete_s;
  logic signed [8:0]       dx_s, dy_s;
  logic signed [EXT_W-1:0] base_x_s, base_y_s, sum_x_s, sum_y_s;

  // Packet-level event decode
  always_comb begin
    in_pkt_s   = (state_r == WAIT_B1) || (state_r == WAIT_B2);
    expire_s   = in_pkt_s && !bus.byte_valid && (tmo_cnt_r == TMO_W'(SYNC_TIMEOUT - 1));
    sync_err_s = (state_r == WAIT_B0) && bus.byte_valid && !bus.byte_in[3];
    complete_s = (state_r == WAIT_B2) && bus.byte_valid;
  end

  // Next-state logic; an arriving byte always beats timeout expiry
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_B0: begin
        if (bus.byte_valid && bus.byte_in[3]) begin
          state_s = WAIT_B1;
        end else begin
          state_s = WAIT_B0;
        end
      end
      WAIT_B1: begin
        if (bus.byte_valid) begin
          state_s = WAIT_B2;
        end else if (expire_s) begin
          state_s = WAIT_B0;
        end else begin
          state_s = WAIT_B1;
        end
      end
      WAIT_B2: begin
        if (bus.byte_valid || expire_s) begin
          state_s = WAIT_B0;
        end else begin
          state_s = WAIT_B2;
        end
      end
      default: state_s = WAIT_B0;
    endcase
  end

  // A tick clears the base first, so a coincident packet lands in the new frame
  always_comb begin
    dx_s     = motion(b0_r[6], b0_r[4], b1_r);
    dy_s     = motion(b0_r[7], b0_r[5], bus.byte_in);
    if (bus.frame_tick) begin
      base_x_s = '0;
      base_y_s = '0;
    end else begin
      base_x_s = EXT_W'(acc_x_r);
      base_y_s = EXT_W'(acc_y_r);
    end
    sum_x_s  = base_x_s + EXT_W'(dx_s);
    sum_y_s  = base_y_s - EXT_W'(dy_s);
    if (complete_s) begin
      acc_x_s = sat_acc(sum_x_s);
      acc_y_s = sat_acc(sum_y_s);
    end else begin
      acc_x_s = base_x_s[ACC_W-1:0];
      acc_y_s = base_y_s[ACC_W-1:0];
    end
  end

  // Packet assembly state, captured header bytes and inter-byte timeout
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r   <= WAIT_B0;
      b0_r      <= 8'h00;
      b1_r      <= 8'h00;
      tmo_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if ((state_r == WAIT_B0) && bus.byte_valid && bus.byte_in[3]) begin
        b0_r <= bus.byte_in;
      end
      if ((state_r == WAIT_B1) && bus.byte_valid) begin
        b1_r <= bus.byte_in;
      end
      if (bus.byte_valid || !in_pkt_s || expire_s) begin
        tmo_cnt_r <= '0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
    end
  end

  // Motion accumulators
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_x_r <= '0;
      acc_y_r <= '0;
    end else begin
      acc_x_r <= acc_x_s;
      acc_y_r <= acc_y_s;
    end
  end

  // Registered outputs: displacement per frame, buttons per packet, error pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_displ_r <= 8'h00;
      y_displ_r <= 8'h00;
      left_r    <= 1'b0;
      right_r   <= 1'b0;
      middle_r  <= 1'b0;
      pkt_err_r <= 1'b0;
    end else begin
      if (bus.frame_tick) begin
        x_displ_r <= clamp_out(acc_x_r);
        y_displ_r <= clamp_out(acc_y_r);
      end
      if (complete_s) begin
        left_r   <= b0_r[0];
        right_r  <= b0_r[1];
        middle_r <= b0_r[2];
      end
      pkt_err_r <= sync_err_s || expire_s;
    end
  end

  assign bus.X_displ = x_displ_r;
  assign bus.Y_displ = y_displ_r;
  assign bus.Left    = left_r;
  assign bus.Right   = right_r;
  assign bus.Middle  = middle_r;
  assign bus.pkt_err = pkt_err_r;

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder with a shortened sync timeout.
module tb_mouse_packet_decoder;
  localparam int ST = 16;

  logic Clk;
  logic Reset_n;
  int   tests;
  int   fails;
  int   err_cnt;
  int   err_base;

  mouse_packet_decoder_if bus ();

  mouse_packet_decoder #(.SYNC_TIMEOUT(ST), .ACC_W(12)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // each one-cycle pulse is seen at exactly one falling edge
  always @(negedge Clk) if (bus.pkt_err === 1'b1) err_cnt++;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    @(posedge Clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_tick();
    bus.frame_tick = 1'b1;
    @(posedge Clk); #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    tests++;
    if (bus.X_displ !== 8'h00 || bus.Y_displ !== 8'h00 || bus.Left !== 1'b0 ||
        bus.pkt_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: X=%h Y=%h L=%b err=%b, required 00 00 0 0",
               bus.X_displ, bus.Y_displ, bus.Left, bus.pkt_err);
    end
    idle(2);
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    err_base = err_cnt;
    do_reset();
    send_tick();
    idle(2);
    tests++;
    if (bus.X_displ !== 8'h00 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL reset_displ: X=%h Y=%h, required 00 00", bus.X_displ, bus.Y_displ);
    end
    tests++;
    if ({bus.Left, bus.Right, bus.Middle} !== 3'b000) begin
      fails++;
      $display("FAIL reset_buttons: LRM=%b, required 000", {bus.Left, bus.Right, bus.Middle});
    end
    tests++;
    if (err_cnt - err_base !== 0) begin
      fails++;
      $display("FAIL reset_err: pulses=%0d, required 0", err_cnt - err_base);
    end
  endtask

  task automatic test_basic();
    send_byte(8'h09);
    send_byte(8'h05);
    send_byte(8'h03);
    tests++;
    if ({bus.Left, bus.Right, bus.Middle} !== 3'b100) begin
      fails++;
      $display("FAIL basic_buttons: LRM=%b, required 100", {bus.Left, bus.Right, bus.Middle});
    end
    tests++;
    if (bus.X_displ !== 8'h00) begin
      fails++;
      $display("FAIL basic_pretick: X=%h, required 00", bus.X_displ);
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h05 || bus.Y_displ !== 8'hFD) begin
      fails++;
      $display("FAIL basic_displ: X=%h Y=%h, required 05 FD", bus.X_displ, bus.Y_displ);
    end
    idle(3);
    tests++;
    if (bus.X_displ !== 8'h05 || bus.Y_displ !== 8'hFD) begin
      fails++;
      $display("FAIL basic_hold: X=%h Y=%h, required 05 FD", bus.X_displ, bus.Y_displ);
    end
  endtask

  task automatic test_negative();
    send_byte(8'h38);
    send_byte(8'hF6);
    send_byte(8'h0A);
    tests++;
    if ({bus.Left, bus.Right, bus.Middle} !== 3'b000) begin
      fails++;
      $display("FAIL neg_buttons: LRM=%b, required 000", {bus.Left, bus.Right, bus.Middle});
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'hF6 || bus.Y_displ !== 8'h7F) begin
      fails++;
      $display("FAIL neg_displ: X=%h Y=%h, required F6 7F", bus.X_displ, bus.Y_displ);
    end
  endtask

  task automatic test_sync_err();
    err_base = err_cnt;
    send_byte(8'h02);
    tests++;
    if (bus.pkt_err !== 1'b1) begin
      fails++;
      $display("FAIL sync_pulse: pkt_err=%b, required 1", bus.pkt_err);
    end
    idle(1);
    tests++;
    if (bus.pkt_err !== 1'b0) begin
      fails++;
      $display("FAIL sync_width: pkt_err=%b, required 0", bus.pkt_err);
    end
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h01);
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h01 || bus.Y_displ !== 8'hFF) begin
      fails++;
      $display("FAIL sync_displ: X=%h Y=%h, required 01 FF", bus.X_displ, bus.Y_displ);
    end
    tests++;
    if (err_cnt - err_base !== 1) begin
      fails++;
      $display("FAIL sync_count: pulses=%0d, required 1", err_cnt - err_base);
    end
  endtask

  task automatic test_timeout();
    err_base = err_cnt;
    send_byte(8'h08);
    send_byte(8'h10);
    idle(ST - 1);
    tests++;
    if (bus.pkt_err !== 1'b0) begin
      fails++;
      $display("FAIL tmo_early: pkt_err=%b, required 0", bus.pkt_err);
    end
    idle(1);
    tests++;
    if (bus.pkt_err !== 1'b1) begin
      fails++;
      $display("FAIL tmo_pulse: pkt_err=%b, required 1", bus.pkt_err);
    end
    send_byte(8'h08);
    send_byte(8'h02);
    send_byte(8'h00);
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h02 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL tmo_displ: X=%h Y=%h, required 02 00", bus.X_displ, bus.Y_displ);
    end
    tests++;
    if (err_cnt - err_base !== 1) begin
      fails++;
      $display("FAIL tmo_count: pulses=%0d, required 1", err_cnt - err_base);
    end
  endtask

  task automatic test_timeout_race();
    err_base = err_cnt;
    send_byte(8'h08);
    send_byte(8'h10);
    idle(ST - 1);
    send_byte(8'h00);
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h10 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL race_displ: X=%h Y=%h, required 10 00", bus.X_displ, bus.Y_displ);
    end
    tests++;
    if (err_cnt - err_base !== 0) begin
      fails++;
      $display("FAIL race_count: pulses=%0d, required 0", err_cnt - err_base);
    end
  endtask

  task automatic test_back_to_back();
    send_tick();
    send_byte(8'h08);
    send_byte(8'h04);
    bus.frame_tick = 1'b1;
    send_byte(8'h00);
    bus.frame_tick = 1'b0;
    tests++;
    if (bus.X_displ !== 8'h00) begin
      fails++;
      $display("FAIL b2b_tickA: X=%h, required 00", bus.X_displ);
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h04 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL b2b_tickB: X=%h Y=%h, required 04 00", bus.X_displ, bus.Y_displ);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hC8);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h7F || bus.Y_displ !== 8'h81) begin
      fails++;
      $display("FAIL sat_pos: X=%h Y=%h, required 7F 81", bus.X_displ, bus.Y_displ);
    end
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hF8);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h81 || bus.Y_displ !== 8'h7F) begin
      fails++;
      $display("FAIL sat_neg: X=%h Y=%h, required 81 7F", bus.X_displ, bus.Y_displ);
    end
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h00 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL sat_clear: X=%h Y=%h, required 00 00", bus.X_displ, bus.Y_displ);
    end
  endtask

  task automatic test_reset_midpacket();
    send_byte(8'h08);
    send_byte(8'h07);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h05);
    do_reset();
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h00);
    send_tick();
    tests++;
    if (bus.X_displ !== 8'h01 || bus.Y_displ !== 8'h00) begin
      fails++;
      $display("FAIL midrst_displ: X=%h Y=%h, required 01 00", bus.X_displ, bus.Y_displ);
    end
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    err_cnt        = 0;
    err_base       = 0;
    Reset_n        = 1'b1;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    bus.frame_tick = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_sync_err();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_saturation();
    test_reset_midpacket();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
